// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_decoder                                                    |
// | Rebuilds BCD digits from a scanned 7-segment bus; publishes a frame  |
// | once it repeats STABLE_FRAMES times. SEG7_DP_EN adds dp_in/dp_out.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample,
  input  logic [0:6]          seg_in,
  input  logic [DIGITS-1:0]   dig_sel,
  input  logic                err_clr,
`ifdef SEG7_DP_EN
  input  logic                dp_in,
  output logic [DIGITS-1:0]   dp_out,
`endif
  output logic [4*DIGITS-1:0] code_out,
  output logic [DIGITS-1:0]   blank_out,
  output logic                update,
  output logic                locked,
  output logic                err
);

  // Each digit slot is {dp (optional), blank, code[3:0]}.
`ifdef SEG7_DP_EN
  localparam int c_sw = 6;
`else
  localparam int c_sw = 5;
`endif
  localparam int              c_fw         = c_sw * DIGITS;
  localparam logic [c_sw-1:0] c_blank_slot = c_sw'(5'h1F);
  localparam logic [3:0]      c_stable     = 4'(STABLE_FRAMES);

  logic [c_fw-1:0]   r_work, r_cand, r_pub;
  logic [DIGITS-1:0] r_mask;
  logic [3:0]        r_cnt;

  logic [3:0]        w_code;
  logic              w_blank, w_legal, w_onehot, w_err_evt;
  logic              w_frame_done, w_eq_cand, w_eq_pub;
  logic [c_sw-1:0]   w_slot;
  logic [c_fw-1:0]   w_frame;
  logic [DIGITS-1:0] w_mask_next;
  logic [3:0]        w_cnt_next;

  always_comb begin
    w_legal = 1'b1;
    w_blank = 1'b0;
    w_code  = 4'hF;
    case (seg_in)
      7'b1111110: w_code = 4'd0;
      7'b0110000: w_code = 4'd1;
      7'b1101101: w_code = 4'd2;
      7'b1111001: w_code = 4'd3;
      7'b0110011: w_code = 4'd4;
      7'b1011011: w_code = 4'd5;
      7'b1011111: w_code = 4'd6;
      7'b1110000: w_code = 4'd7;
      7'b1111111: w_code = 4'd8;
      7'b1110011: w_code = 4'd9;
      7'b0000000: w_blank = 1'b1;
      default:    w_legal = 1'b0;
    endcase
  end

`ifdef SEG7_DP_EN
  assign w_slot = {dp_in, w_blank, w_code};
`else
  assign w_slot = {w_blank, w_code};
`endif

  assign w_onehot  = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
  assign w_err_evt = sample && !(w_legal && w_onehot);

  // Working frame as it will look once the current sample is written in.
  always_comb begin
    w_frame = r_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_sel[i]) w_frame[i*c_sw +: c_sw] = w_slot;
    end
  end

  assign w_mask_next  = r_mask | dig_sel;
  assign w_frame_done = &w_mask_next;
  assign w_eq_cand    = (w_frame == r_cand);
  assign w_eq_pub     = (w_frame == r_pub);
  assign w_cnt_next   = !w_eq_cand ? 4'd1 :
                        (r_cnt >= c_stable) ? c_stable : r_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= {DIGITS{c_blank_slot}};
      r_cand <= {DIGITS{c_blank_slot}};
      r_pub  <= {DIGITS{c_blank_slot}};
      r_mask <= '0;
      r_cnt  <= 4'd0;
      update <= 1'b0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      update <= 1'b0;
      if (w_err_evt) begin
        r_mask <= '0;
        r_cnt  <= 4'd0;
        locked <= 1'b0;
      end else if (sample) begin
        r_work <= w_frame;
        if (w_frame_done) begin
          r_mask <= '0;
          r_cand <= w_frame;
          r_cnt  <= w_cnt_next;
          if (w_cnt_next == c_stable && !w_eq_pub) begin
            r_pub  <= w_frame;
            update <= 1'b1;
            locked <= 1'b1;
          end else begin
            locked <= w_eq_pub;
          end
        end else begin
          r_mask <= w_mask_next;
        end
      end
      // A new error event outranks a clear request in the same cycle.
      if (w_err_evt)    err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_out
    assign code_out[4*g +: 4] = r_pub[g*c_sw +: 4];
    assign blank_out[g]       = r_pub[g*c_sw + 4];
`ifdef SEG7_DP_EN
    assign dp_out[g]          = r_pub[g*c_sw + 5];
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// Randomized self-checking bench for seg7_scan_decoder against a digit-level
// reference model (values 0..9, 15 = blank, -1 = illegal).
module tb_seg7_scan_decoder;
  localparam int DIGITS        = 4;
  localparam int STABLE_FRAMES = 2;
`ifdef SEG7_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                sample = 1'b0;
  logic [0:6]          seg_in = '0;
  logic [DIGITS-1:0]   dig_sel = '0;
  logic                err_clr = 1'b0;
  logic [4*DIGITS-1:0] code_out;
  logic [DIGITS-1:0]   blank_out;
  logic                update, locked, err;
`ifdef SEG7_DP_EN
  logic                dp_in = 1'b0;
  logic [DIGITS-1:0]   dp_out;
`endif

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_FRAMES(STABLE_FRAMES)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .seg_in(seg_in),
    .dig_sel(dig_sel), .err_clr(err_clr),
`ifdef SEG7_DP_EN
    .dp_in(dp_in), .dp_out(dp_out),
`endif
    .code_out(code_out), .blank_out(blank_out), .update(update),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // index 10 is the blank pattern
  logic [0:6] pat_tab [0:10];

  // reference model state
  int w_val [DIGITS];
  bit w_dp  [DIGITS];
  int c_val [DIGITS];
  bit c_dp  [DIGITS];
  int p_val [DIGITS];
  bit p_dp  [DIGITS];
  bit seen  [DIGITS];
  int cnt;
  bit m_update, m_locked, m_err;

  function automatic int decode(input logic [0:6] p);
    for (int k = 0; k <= 10; k++)
      if (p == pat_tab[k]) return (k == 10) ? 15 : k;
    return -1;
  endfunction

  function automatic longint pack(input int v[DIGITS], input bit d[DIGITS]);
    longint key = 0;
    for (int i = 0; i < DIGITS; i++) key = key * 64 + longint'(v[i]) * 2 + longint'(d[i]);
    return key;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) begin
      w_val[i] = 15; c_val[i] = 15; p_val[i] = 15;
      w_dp[i] = 0;   c_dp[i] = 0;   p_dp[i] = 0;
      seen[i] = 0;
    end
    cnt = 0; m_update = 0; m_locked = 0; m_err = 0;
  endtask

  task automatic model_step(input bit smp, input logic [0:6] seg,
                            input logic [DIGITS-1:0] sel, input bit clr, input bit dp);
    bit ev = 0;
    bit all_seen;
    int d;
    m_update = 0;
    if (smp) begin
      d = decode(seg);
      if (d < 0 || $countones(sel) != 1) begin
        ev = 1; cnt = 0; m_locked = 0;
        for (int i = 0; i < DIGITS; i++) seen[i] = 0;
      end else begin
        all_seen = 1;
        for (int i = 0; i < DIGITS; i++) begin
          if (sel[i]) begin w_val[i] = d; w_dp[i] = dp & DP_EN; seen[i] = 1; end
          all_seen &= seen[i];
        end
        if (all_seen) begin
          for (int i = 0; i < DIGITS; i++) seen[i] = 0;
          if (pack(w_val, w_dp) == pack(c_val, c_dp)) begin
            cnt = (cnt < STABLE_FRAMES) ? cnt + 1 : STABLE_FRAMES;
          end else begin
            c_val = w_val; c_dp = w_dp; cnt = 1;
          end
          if (cnt == STABLE_FRAMES && pack(c_val, c_dp) != pack(p_val, p_dp)) begin
            p_val = c_val; p_dp = c_dp; m_update = 1; m_locked = 1;
          end else begin
            m_locked = (pack(w_val, w_dp) == pack(p_val, p_dp));
          end
        end
      end
    end
    if (ev) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic check_all();
    logic [4*DIGITS-1:0] ec;
    logic [DIGITS-1:0]   eb, ed;
    for (int i = 0; i < DIGITS; i++) begin
      ec[4*i +: 4] = 4'(p_val[i]);
      eb[i] = (p_val[i] == 15);
      ed[i] = p_dp[i];
    end
    check_eq("code_out", 32'(code_out), 32'(ec));
    check_eq("blank_out", 32'(blank_out), 32'(eb));
    check_eq("update", 32'(update), 32'(m_update));
    check_eq("locked", 32'(locked), 32'(m_locked));
    check_eq("err", 32'(err), 32'(m_err));
`ifdef SEG7_DP_EN
    check_eq("dp_out", 32'(dp_out), 32'(ed));
`else
    if (ed != '0) check_eq("dp_model", 32'(ed), 32'd0);
`endif
  endtask

  task automatic cycle(input bit smp, input logic [0:6] seg,
                       input logic [DIGITS-1:0] sel, input bit clr, input bit dp);
    @(negedge clk);
    sample = smp; seg_in = seg; dig_sel = sel; err_clr = clr;
`ifdef SEG7_DP_EN
    dp_in = dp;
`endif
    @(posedge clk);
    model_step(smp, seg, sel, clr, dp);
    #1 check_all();
  endtask

  task automatic put_digit(input int i, input int pidx, input bit dp);
    cycle(1'b1, pat_tab[pidx], DIGITS'(1) << i, 1'b0, dp);
  endtask

  task automatic frame4(input int a, input int b, input int c, input int d);
    put_digit(0, a, 0); put_digit(1, b, 0); put_digit(2, c, 0); put_digit(3, d, 0);
  endtask

  function automatic logic [0:6] rand_illegal();
    logic [0:6] p;
    do p = 7'($urandom); while (decode(p) >= 0);
    return p;
  endfunction

  function automatic logic [DIGITS-1:0] rand_bad_sel();
    logic [DIGITS-1:0] s;
    do s = DIGITS'($urandom); while ($countones(s) == 1);
    return s;
  endfunction

  int  tv  [DIGITS];
  bit  tdp [DIGITS];

  initial begin
    pat_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011,
                7'b0000000};
    model_reset();

    // reset state
    #12;
    check_eq("rst_code", 32'(code_out), 32'h0000FFFF);
    check_eq("rst_blank", 32'(blank_out), 32'hF);
    check_eq("rst_flags", 32'({update, locked, err}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1,2,3,4 scanned twice: single update one cycle after the 8th sample
    frame4(1, 2, 3, 4);
    check_eq("no_early_update", 32'(update), 32'd0);
    frame4(1, 2, 3, 4);
    check_eq("first_update", 32'(update), 32'd1);
    check_eq("first_code", 32'(code_out), 32'h4321);
    check_eq("first_locked", 32'(locked), 32'd1);

    // one-frame glitch on digit 2, then back
    frame4(1, 2, 5, 4);
    check_eq("glitch_unlock", 32'(locked), 32'd0);
    frame4(1, 2, 3, 4);
    check_eq("relock", 32'(locked), 32'd1);
    check_eq("relock_code", 32'(code_out), 32'h4321);

    // illegal pattern mid-frame, then err_clr, then two clean frames
    put_digit(0, 7, 0); put_digit(1, 8, 0);
    cycle(1'b1, 7'b1000001, 4'b0100, 1'b0, 1'b0);
    check_eq("illegal_err", 32'(err), 32'd1);
    cycle(1'b0, 7'b0, 4'b0, 1'b1, 1'b0);
    check_eq("err_clr", 32'(err), 32'd0);
    frame4(7, 8, 9, 0);
    check_eq("one_frame_no_update", 32'(code_out), 32'h4321);
    frame4(7, 8, 9, 0);
    check_eq("new_code", 32'(code_out), 32'h0987);

    // multi-hot select, then blank digit 3 over two frames
    cycle(1'b1, pat_tab[1], 4'b0011, 1'b0, 1'b0);
    check_eq("multihot_err", 32'(err), 32'd1);
    frame4(7, 8, 9, 10);
    frame4(7, 8, 9, 10);
    check_eq("blank3", 32'(blank_out[3]), 32'd1);
    check_eq("blank3_code", 32'(code_out[15:12]), 32'hF);

`ifdef SEG7_DP_EN
    frame4(7, 8, 9, 10);
    put_digit(0, 7, 1); put_digit(1, 8, 0); put_digit(2, 9, 0); put_digit(3, 10, 0);
    put_digit(0, 7, 1); put_digit(1, 8, 0); put_digit(2, 9, 0); put_digit(3, 10, 0);
    check_eq("dp_out", 32'(dp_out), 32'h1);
    check_eq("dp_code", 32'(code_out), 32'hF987);
`endif

    // asynchronous reset mid-frame
    put_digit(0, 3, 0); put_digit(1, 3, 0);
    @(negedge clk); sample = 1'b0; rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk); rst_n = 1'b1;

    // randomized scanning with occasional digit changes and faults
    for (int i = 0; i < DIGITS; i++) begin tv[i] = $urandom_range(0, 10); tdp[i] = 0; end
    repeat (300) begin
      int off;
      if ($urandom_range(0, 99) < 15) tv[$urandom_range(0, DIGITS-1)] = $urandom_range(0, 10);
      if ($urandom_range(0, 99) < 5)  tdp[$urandom_range(0, DIGITS-1)] ^= 1'b1;
      off = $urandom_range(0, DIGITS-1);
      for (int k = 0; k < DIGITS; k++) begin
        int idx = (off + k) % DIGITS;
        if ($urandom_range(0, 9) == 0)
          cycle(1'b0, 7'($urandom), DIGITS'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
        if ($urandom_range(0, 59) == 0)
          cycle(1'b1, rand_illegal(), DIGITS'(1) << idx, ($urandom_range(0, 1) == 0), 1'b0);
        else if ($urandom_range(0, 59) == 0)
          cycle(1'b1, pat_tab[tv[idx]], rand_bad_sel(), ($urandom_range(0, 1) == 0), 1'b0);
        if ($urandom_range(0, 29) == 0)
          put_digit($urandom_range(0, DIGITS-1), $urandom_range(0, 10), 1'($urandom));
        cycle(1'b1, pat_tab[tv[idx]], DIGITS'(1) << idx, ($urandom_range(0, 15) == 0), tdp[idx]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
